// File: rtl/xor_parity_rx.sv
// xor_parity_rx
//   Receive side of the XOR-parity serial link. It collects DATA_W data bits
//   (LSB first) and then one parity bit. It recomputes the XOR of the data bits
//   and presents the word with a parity-error flag on a valid/ready port.
//
// Parameters
//   DATA_W : data bits per frame (2..32)
//   ODD    : 0 = even parity, 1 = odd parity
//
// Ports
//   clk, rst   : clock and synchronous active-high reset
//   bit_in     : serial line bit, qualified by bit_valid
//   bit_valid  : bit_in carries a line bit this cycle
//   sof        : with bit_valid, marks the current bit as data bit 0
//   out_data   : received word, bit 0 = first bit received
//   out_perr   : parity mismatch for the word on out_data
//   out_valid  : out_data/out_perr hold a word not yet accepted
//   out_ready  : consumer accepts the word when out_valid is also 1
//   overrun    : sticky flag, a completed frame was dropped (output occupied)
//   busy       : a frame is in progress
module xor_parity_rx #(
  parameter int DATA_W = 8,
  parameter bit ODD    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic              busy
);

  // Wide enough to hold DATA_W itself, so the increment after the last data
  // bit cannot wrap.
  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                xor_reg;
  logic [DATA_W-1:0]   shift_reg;
  logic [DATA_W-1:0]   shift_next;
  logic [DATA_W-1:0]   out_data_reg;
  logic                out_perr_reg;
  logic                out_valid_reg;
  logic                overrun_reg;

  logic                start_bit;
  logic                data_bit;
  logic                par_bit;
  logic                last_data;
  logic                wr_en;
  logic [CNT_W-1:0]    wr_pos;
  logic                frame_perr;
  logic                slot_free;

  // sof with bit_valid restarts the frame in any state. A partial frame is
  // abandoned without raising any flag.
  assign start_bit  = bit_valid & sof;
  assign data_bit   = bit_valid & ~sof & (state_reg == DATA);
  assign par_bit    = bit_valid & ~sof & (state_reg == PAR);
  assign last_data  = data_bit & (cnt_reg == CNT_W'(DATA_W - 1));

  assign wr_en      = start_bit | data_bit;
  assign wr_pos     = start_bit ? '0 : cnt_reg;

  assign frame_perr = xor_reg ^ bit_in ^ ODD;

  // The output register can take a new word if it is empty, or if its current
  // word is accepted in this same cycle.
  assign slot_free  = ~out_valid_reg | out_ready;

  // Each shift-register bit is loaded only when its own position is written.
  // The other bits keep their values.
  generate
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_shift
      assign shift_next[gi] = (wr_en && (wr_pos == CNT_W'(gi))) ? bit_in
                                                                 : shift_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      xor_reg       <= 1'b0;
      shift_reg     <= '0;
      out_data_reg  <= '0;
      out_perr_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      shift_reg <= shift_next;

      // Frame sequencing.
      if (start_bit) begin
        state_reg <= DATA;
        cnt_reg   <= CNT_W'(1);
        xor_reg   <= bit_in;
      end else if (data_bit) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        xor_reg <= xor_reg ^ bit_in;
        if (last_data) begin
          state_reg <= PAR;
        end
      end else if (par_bit) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        xor_reg   <= 1'b0;
      end

      // Output register and handshake.
      if (par_bit) begin
        if (slot_free) begin
          out_data_reg  <= shift_reg;
          out_perr_reg  <= frame_perr;
          out_valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_perr  = out_perr_reg;
  assign out_valid = out_valid_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_xor_parity_rx.sv
// Testbench for xor_parity_rx with DATA_W=8. One instance uses even parity and
// a second uses odd parity. Both share the same stimulus. A frame-level model
// predicts the outputs, and a compare process checks them on every falling edge.
module tb_xor_parity_rx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          bit_in = 1'b0;
  logic          bit_valid = 1'b0;
  logic          sof = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data_e, out_data_o;
  logic          out_perr_e, out_perr_o;
  logic          out_valid_e, out_valid_o;
  logic          overrun_e, overrun_o;
  logic          busy_e, busy_o;

  xor_parity_rx #(.DATA_W(DW), .ODD(1'b0)) dut_even (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(out_data_e), .out_perr(out_perr_e), .out_valid(out_valid_e),
    .out_ready(out_ready), .overrun(overrun_e), .busy(busy_e)
  );

  xor_parity_rx #(.DATA_W(DW), .ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(out_data_o), .out_perr(out_perr_o), .out_valid(out_valid_o),
    .out_ready(out_ready), .overrun(overrun_o), .busy(busy_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: the bits of the frame in progress, and the output register.
  bit            frame_q[$];
  bit            in_frame = 1'b0;
  logic [DW-1:0] exp_data = '0;
  bit            exp_perr_e = 1'b0;
  bit            exp_perr_o = 1'b0;
  bit            exp_valid = 1'b0;
  bit            exp_ovr = 1'b0;
  int            outputs_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge with the given inputs.
  task automatic model_step(input bit r, input bit v, input bit s, input bit b, input bit rd);
    bit            done;
    logic [DW-1:0] word;
    bit            par_even;
    done = 1'b0;
    word = '0;
    par_even = 1'b0;
    if (r) begin
      frame_q.delete();
      in_frame   = 1'b0;
      exp_data   = '0;
      exp_perr_e = 1'b0;
      exp_perr_o = 1'b0;
      exp_valid  = 1'b0;
      exp_ovr    = 1'b0;
      return;
    end
    if (v) begin
      if (s) begin
        frame_q.delete();
        frame_q.push_back(b);
        in_frame = 1'b1;
      end else if (in_frame) begin
        if (frame_q.size() < DW) begin
          frame_q.push_back(b);
        end else begin
          foreach (frame_q[i]) word[i] = frame_q[i];
          // The frame is good (even sense) when the data ones plus the parity bit count to an even number.
          par_even = (($countones(word) + int'(b)) % 2) != 0;
          done = 1'b1;
          frame_q.delete();
          in_frame = 1'b0;
        end
      end
    end
    if (done) begin
      if (!exp_valid || rd) begin
        exp_data   = word;
        exp_perr_e = par_even;
        exp_perr_o = !par_even;
        exp_valid  = 1'b1;
        outputs_seen++;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && rd) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic cyc(input bit r, input bit v, input bit s, input bit b, input bit rd);
    @(negedge clk);
    rst = r; bit_valid = v; sof = s; bit_in = b; out_ready = rd;
    @(posedge clk);
    #1;
    model_step(r, v, s, b, rd);
  endtask

  function automatic bit pick_rdy(input int mode);
    if (mode == 2) return 1'($urandom_range(0, 1));
    return (mode == 1);
  endfunction

  // Send a whole frame. rdy_mode: 0 = ready low, 1 = ready high, 2 = random.
  task automatic send_bits(input logic [DW-1:0] w, input bit p, input int nbits,
                           input int maxgap, input int rdy_mode);
    for (int i = 0; i < nbits; i++) begin
      int gap;
      gap = $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++)
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_rdy(rdy_mode));
      cyc(1'b0, 1'b1, (i == 0), (i < DW) ? w[i] : p, pick_rdy(rdy_mode));
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input bit p, input int maxgap, input int rdy_mode);
    send_bits(w, p, DW + 1, maxgap, rdy_mode);
  endtask

  // Compare process: checks the DUT outputs against the model on every cycle after the first reset.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid_even", 32'(out_valid_e), 32'(exp_valid));
      chk("valid_odd",  32'(out_valid_o), 32'(exp_valid));
      chk("overrun_even", 32'(overrun_e), 32'(exp_ovr));
      chk("overrun_odd",  32'(overrun_o), 32'(exp_ovr));
      chk("busy_even", 32'(busy_e), 32'(in_frame));
      chk("busy_odd",  32'(busy_o), 32'(in_frame));
      if (exp_valid) begin
        chk("data_even", 32'(out_data_e), 32'(exp_data));
        chk("data_odd",  32'(out_data_o), 32'(exp_data));
        chk("perr_even", 32'(out_perr_e), 32'(exp_perr_e));
        chk("perr_odd",  32'(out_perr_o), 32'(exp_perr_o));
      end
    end
  end

  initial begin
    int n_before;

    // Reset
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    $display("reset: valid=%0b data=%0h overrun=%0b busy=%0b", out_valid_e, out_data_e, overrun_e, busy_e);
    chk("reset_valid", 32'(out_valid_e), 32'd0);
    chk("reset_data", 32'(out_data_e), 32'd0);
    chk("reset_perr", 32'(out_perr_e), 32'd0);
    chk("reset_overrun", 32'(overrun_e), 32'd0);
    chk("reset_busy", 32'(busy_e), 32'd0);

    // 0xA5, parity 0: even instance reports no error, odd instance reports an error.
    send_frame(8'hA5, 1'b0, 0, 0);
    $display("frame A5 p0: valid=%0b data=%0h perr_e=%0b perr_o=%0b", out_valid_e, out_data_e, out_perr_e, out_perr_o);
    chk("a5p0_model", 32'(exp_data), 32'h0A5);
    chk("a5p0_valid", 32'(out_valid_e), 32'd1);
    chk("a5p0_data", 32'(out_data_e), 32'h0A5);
    chk("a5p0_perr_e", 32'(out_perr_e), 32'd0);
    chk("a5p0_perr_o", 32'(out_perr_o), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("a5p0_accepted", 32'(out_valid_e), 32'd0);

    // 0xA5, parity 1: even instance reports an error, odd instance does not.
    send_frame(8'hA5, 1'b1, 0, 1);
    $display("frame A5 p1: data=%0h perr_e=%0b perr_o=%0b", out_data_e, out_perr_e, out_perr_o);
    chk("a5p1_perr_e", 32'(out_perr_e), 32'd1);
    chk("a5p1_perr_o", 32'(out_perr_o), 32'd0);
    chk("a5p1_model", 32'(exp_perr_e), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 0x3C with gaps between bits. The compare process checks busy during the gaps.
    send_frame(8'h3C, 1'b0, 3, 0);
    $display("frame 3C gaps: data=%0h perr_e=%0b", out_data_e, out_perr_e);
    chk("3c_data", 32'(out_data_e), 32'h03C);
    chk("3c_perr", 32'(out_perr_e), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Overrun: the second frame is dropped while the output is not accepted.
    send_frame(8'h01, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b0, 0, 0);
    $display("overrun: data=%0h overrun=%0b", out_data_e, overrun_e);
    chk("ovr_data", 32'(out_data_e), 32'h001);
    chk("ovr_flag", 32'(overrun_e), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_accept", 32'(out_valid_e), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr_once", 32'(out_valid_e), 32'd0);

    // Reset at data bit 4, then frame 0x55.
    send_bits(8'hF0, 1'b0, 4, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    $display("mid-frame reset: valid=%0b data=%0h overrun=%0b busy=%0b", out_valid_e, out_data_e, overrun_e, busy_e);
    chk("rst_mid_busy", 32'(busy_e), 32'd0);
    chk("rst_mid_overrun", 32'(overrun_e), 32'd0);
    chk("rst_mid_data", 32'(out_data_e), 32'd0);
    n_before = outputs_seen;
    send_frame(8'h55, 1'b0, 0, 0);
    $display("frame 55: data=%0h perr_e=%0b", out_data_e, out_perr_e);
    chk("55_data", 32'(out_data_e), 32'h055);
    chk("55_perr", 32'(out_perr_e), 32'd0);
    chk("55_single", 32'(outputs_seen - n_before), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Bits without sof while idle are dropped.
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    chk("idle_no_out", 32'(out_valid_e), 32'd0);

    // Frame aborted after 5 bits, then 0x81. Only 0x81 is output.
    send_bits(8'h3F, 1'b0, 5, 0, 0);
    send_frame(8'h81, 1'b0, 0, 0);
    $display("abort then 81: data=%0h perr_e=%0b overrun=%0b", out_data_e, out_perr_e, overrun_e);
    chk("abort_data", 32'(out_data_e), 32'h081);
    chk("abort_perr", 32'(out_perr_e), 32'd0);
    chk("abort_ovr", 32'(overrun_e), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random back-to-back frames with random gaps, aborts and ready.
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 9) == 0)
        send_bits(8'($urandom), 1'b0, $urandom_range(1, DW), 1, 2);
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 2);
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if ($urandom_range(0, 49) == 0) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Unstructured random line activity.
    for (int c = 0; c < 1500; c++) begin
      bit v;
      v = ($urandom_range(0, 9) < 7);
      cyc(($urandom_range(0, 299) == 0), v, ($urandom_range(0, 11) == 0),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_parity_rx.md
Name: xor_parity_rx

Overview:
- Receiving end of the XOR-parity serial link: deserializes one frame of DATA_W data bits, LSB first, followed by one parity bit.
- Recomputes the XOR reduction of the data bits and compares it with the received parity bit.
- Presents the word plus a parity-error flag on a valid/ready output port.
- Sits between the serial line front end and the consuming register block.

Parameters:
- DATA_W, 8, number of data bits per frame (legal range 2..32).
- ODD, 0, parity sense: 0 = even parity (XOR of data bits plus parity bit is 0); 1 = odd parity (XOR of data bits plus parity bit is 1).

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_in  input  1  serial data bit; sampled only when bit_valid=1.
- bit_valid  input  1  bit_in carries a line bit this cycle.
- sof  input  1  start of frame; qualified by bit_valid; marks the current bit as data bit 0.
- out_data  output  DATA_W  received data word, bit 0 = first bit received.
- out_perr  output  1  parity mismatch for the word on out_data.
- out_valid  output  1  out_data and out_perr are valid.
- out_ready  input  1  consumer accepts the word when out_valid and out_ready are both 1.
- overrun  output  1  sticky: a completed frame was dropped because the output register was occupied.
- busy  output  1  a frame is in progress (state is not IDLE).

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, bit counter=0, running XOR=0, shift register=0, out_data=0, out_perr=0, out_valid=0, overrun=0. Reset wins over every other event, including mid-frame; any partial frame is discarded.
- Cycles with bit_valid=0 are ignored in all states: no state, counter or XOR change. Gaps between bits are allowed.
- State IDLE:
  - bit_valid=1 and sof=1: store bit_in at shift-register position 0, running XOR=bit_in, counter=1, go to DATA. If DATA_W=1 were legal this would skip to PAR; DATA_W>=2 is required.
  - bit_valid=1 and sof=0: bit dropped, stay in IDLE.
- State DATA:
  - bit_valid=1 and sof=0: store bit_in at position counter, XOR it into the running XOR, counter+1.
  - When the stored bit is position DATA_W-1, go to PAR.
- State PAR, on bit_valid=1 and sof=0 (this bit is the parity bit):
  - perr = running_xor ^ bit_in ^ ODD.
  - Frame complete; go to IDLE and clear counter and XOR.
- sof=1 with bit_valid=1 in DATA or PAR: the current frame is aborted silently (no output, no overrun). The bit becomes data bit 0 of a new frame, exactly as in IDLE.
- Output register on frame completion:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: load out_data and out_perr, and out_valid=1 on the next edge. Latency is 1 clock from the parity-bit sample edge to out_valid visible.
  - If out_valid=1 and out_ready=0: the new frame is dropped, out_data and out_perr are unchanged, overrun is set to 1.
- Handshake:
  - out_valid stays 1 and out_data/out_perr stay stable until the accepting cycle (out_valid and out_ready both 1).
  - After acceptance, out_valid goes to 0 unless a new frame completes in the same cycle, in which case it stays 1 with the new contents.
- overrun clears only on rst.
- busy is 1 in DATA and PAR, 0 in IDLE.
- Back-to-back frames:
  - The parity bit of frame N and sof of frame N+1 can arrive in consecutive cycles.
  - No dead cycle is required between frames.

Test Plan:
- DATA_W=8, ODD=0: send 0xA5 LSB-first with sof on bit 0, then parity 0 -> one clock after the parity bit, out_valid=1, out_data=0xA5, out_perr=0.
- Same frame with parity bit 1 -> out_data=0xA5, out_perr=1. Repeat with ODD=1 and parity 1 -> out_perr=0.
- Send 0x3C with random bit_valid gaps of 0-3 cycles between bits -> out_data=0x3C, out_perr=0; busy stays 1 through the gaps.
- Hold out_ready=0, send 0x01 (parity 1) then 0xFF (parity 0) -> out_data stays 0x01 and overrun=1. Raise out_ready -> 0x01 is accepted once, then out_valid=0.
- Send 5 bits of a frame, then sof with a new frame 0x81 (parity 0) -> only 0x81 is output, out_perr=0, overrun=0.
- Assert rst at data bit 4 of a frame, then send 0x55 (parity 0) -> all outputs are 0 after reset, then a single output 0x55 with out_perr=0. Also send bits with sof=0 while in IDLE -> no output produced.
